// File: rtl/priority_decoder.sv
// priority_decoder
//   Queues 3-bit encoded indices in a DEPTH-entry FIFO and presents each one
//   as an 8-bit one-hot value on y for max(hold,1) consecutive cycles.
//   Codes are presented in arrival order. A new code can follow the previous
//   one with no idle cycle between them.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : permits a queued code to start being presented
//   in       : encoded index 0..7
//   in_valid : qualifies in
//   in_ready : queue can accept a code (count < DEPTH)
//   hold     : presentation length in cycles; sampled at pop, 0 acts as 1
//   y        : one-hot decoded value, zero when idle
//   y_valid  : y carries a decoded code
//   busy     : queue non-empty or a code being presented
module priority_decoder #(
   parameter int DEPTH  = 4,
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [2:0]        in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [HOLD_W-1:0] hold,
   output logic [7:0]        y,
   output logic              y_valid,
   output logic              busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [2:0]        mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [HOLD_W-1:0] hcnt, hcnt_nxt, hold_load;
   logic [7:0]        y_nxt;
   logic              push, pop;

   // in_ready comes from the registered count only, so a full queue refuses
   // a push even in a cycle where the FSM pops.
   always_comb begin
      in_ready  = (count < DEPTH_C);
      push      = in_valid && in_ready;
      hold_load = (hold == '0) ? '0 : hold - 1'b1;
   end

   // Storage carries no reset; discarding queued codes is done by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // State register, with the presentation datapath held alongside it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hcnt  <= '0;
         y     <= '0;
      end else begin
         state <= state_nxt;
         hcnt  <= hcnt_nxt;
         y     <= y_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      y_nxt     = y;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (en && (count != '0)) begin
               pop       = 1'b1;
               y_nxt     = 8'b1 << mem[rd_ptr];
               hcnt_nxt  = hold_load;
               state_nxt = ACTIVE;
            end else begin
               y_nxt = '0;
            end
         end
         ACTIVE: begin
            if (hcnt != '0) begin
               hcnt_nxt = hcnt - 1'b1;
            end else if (en && (count != '0)) begin
               // back-to-back: next code replaces the current one directly
               pop      = 1'b1;
               y_nxt    = 8'b1 << mem[rd_ptr];
               hcnt_nxt = hold_load;
            end else begin
               y_nxt     = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            y_nxt     = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      y_valid = (state == ACTIVE);
      busy    = (count != '0) || y_valid;
   end

endmodule

// File: tb/tb_priority_decoder.sv
module tb_priority_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [2:0] in;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] hold;
   logic [7:0] y;
   logic       y_valid;
   logic       busy;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;

   // one entry per expected presentation cycle
   logic [7:0] exp_q[$];

   priority_decoder #(.DEPTH(4), .HOLD_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .in      (in),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .hold    (hold),
      .y       (y),
      .y_valid (y_valid),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] got,
                                 input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   // Monitor: pops one expected value per presented cycle
   always @(negedge clk) begin
      if (y_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_y: got %0h expected none at %0t", y, $time);
         end else begin
            check("y_value", {24'd0, y}, {24'd0, exp_q.pop_front()});
         end
      end else begin
         check("y_idle_zero", {24'd0, y}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a code and wait for it to be accepted; records the cycles it
   // is expected to occupy on y.
   task automatic push_code(input logic [2:0] c, input int unsigned ncyc);
      int unsigned t;
      for (int unsigned k = 0; k < ncyc; k++) exp_q.push_back(8'b1 << c);
      in       = c;
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) check("push_timeout", 32'd1, 32'd0);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned t = 0;
      while ((busy === 1'b1 || exp_q.size() != 0) && t < 200) begin
         tick();
         t++;
      end
      check("drain_timeout", {31'd0, t >= 200}, 32'd0);
      tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      in       = '0;
      in_valid = 1'b0;
      hold     = 4'd1;
      #12;
      check("rst_y",        {24'd0, y},     32'd0);
      check("rst_y_valid",  {31'd0, y_valid}, 32'd0);
      check("rst_busy",     {31'd0, busy},  32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // single code, hold 1, one-cycle latency
      en   = 1'b1;
      hold = 4'd1;
      push_code(3'd3, 1);
      check("lat_not_yet", {31'd0, y_valid}, 32'd0);
      tick();
      check("lat_y",       {24'd0, y}, 32'h08);
      check("lat_y_valid", {31'd0, y_valid}, 32'd1);
      tick();
      check("single_end_valid", {31'd0, y_valid}, 32'd0);
      check("single_end_busy",  {31'd0, busy}, 32'd0);
      wait_drain();

      // hold 3, back-to-back with no gap
      hold = 4'd3;
      push_code(3'd0, 3);
      push_code(3'd7, 3);
      for (int unsigned k = 0; k < 6; k++) begin
         if (k == 0) begin
            int unsigned t = 0;
            while (y_valid !== 1'b1 && t < 10) begin
               tick();
               t++;
            end
         end
         check("b2b_contiguous", {31'd0, y_valid}, 32'd1);
         tick();
      end
      check("b2b_end", {31'd0, y_valid}, 32'd0);
      wait_drain();

      // fill while disabled; overflow offer ignored
      en   = 1'b0;
      hold = 4'd1;
      push_code(3'd1, 1);
      push_code(3'd2, 1);
      push_code(3'd4, 1);
      push_code(3'd5, 1);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_busy",     {31'd0, busy}, 32'd1);
      in       = 3'd6;
      in_valid = 1'b1;
      tick();
      tick();
      check("full_still", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      en       = 1'b1;
      wait_drain();

      // hold 0 behaves as 1
      hold = 4'd0;
      push_code(3'd2, 1);
      push_code(3'd6, 1);
      wait_drain();

      // hold sampled only at pop: 2 for the first code, 5 for the next
      en   = 1'b0;
      hold = 4'd2;
      push_code(3'd4, 2);
      push_code(3'd1, 5);
      en = 1'b1;
      tick();
      check("hold_first_pop", {24'd0, y}, 32'h10);
      hold = 4'd5;
      wait_drain();

      // full queue + pop + push offered in the same cycle
      en   = 1'b0;
      hold = 4'd1;
      push_code(3'd0, 1);
      push_code(3'd1, 1);
      push_code(3'd2, 1);
      push_code(3'd3, 1);
      in       = 3'd7;
      in_valid = 1'b1;
      en       = 1'b1;
      tick();
      in_valid = 1'b0;
      check("full_pop_ready", {31'd0, in_ready}, 32'd1);
      wait_drain();

      // reset mid-hold with codes queued
      en   = 1'b1;
      hold = 4'd4;
      push_code(3'd5, 4);
      push_code(3'd6, 4);
      push_code(3'd7, 4);
      tick();
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("arst_y",       {24'd0, y}, 32'd0);
      check("arst_y_valid", {31'd0, y_valid}, 32'd0);
      check("arst_busy",    {31'd0, busy}, 32'd0);
      check("arst_ready",   {31'd0, in_ready}, 32'd1);
      tick();
      rst_n = 1'b1;
      for (int unsigned k = 0; k < 8; k++) tick();
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      hold = 4'd1;
      push_code(3'd5, 1);
      tick();
      check("post_rst_first", {24'd0, y}, 32'h20);
      wait_drain();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the code queue depth; it SHALL be a power of two and at least 2.
REQ-002 The parameter HOLD_W SHALL default to 4 and set the width of the hold input.
REQ-003 The port clk SHALL be an input of 1 bit and be the single clock; all state SHALL change on its rising edge.
REQ-004 The port rst_n SHALL be an input of 1 bit that acts as the reset: asynchronous and active-low.
REQ-005 The port en SHALL be an input of 1 bit; while it is 1, queued codes may start.
REQ-006 The port in SHALL be an input of 3 bits carrying the encoded index (0-7) to decode.
REQ-007 The port in_valid SHALL be an input of 1 bit that qualifies in.
REQ-008 The port in_ready SHALL be an output of 1 bit that is 1 while the queue can accept a code.
REQ-009 The port hold SHALL be an input of HOLD_W bits giving the number of cycles each one-hot output is presented.
REQ-010 The port y SHALL be an output of 8 bits carrying the decoded one-hot value, or zero when idle.
REQ-011 The port y_valid SHALL be an output of 1 bit that is 1 while y carries a decoded code.
REQ-012 The port busy SHALL be an output of 1 bit that is 1 while the queue is non-empty or y_valid is 1.

Function
REQ-013 A code SHALL be accepted on a rising edge where in_valid=1 and in_ready=1, and written at the tail of a DEPTH-entry FIFO.
REQ-014 in_ready SHALL equal (count < DEPTH), derived from registered count only; a full queue SHALL reject a push even when a pop occurs in the same cycle.
REQ-015 Write and read pointers SHALL wrap modulo DEPTH; count SHALL be DEPTH+1 values wide (0..DEPTH); simultaneous push and pop SHALL leave count unchanged.
REQ-016 Offers with in_valid=1 and in_ready=0 SHALL be ignored, with no state change.
REQ-017 The FSM SHALL have exactly two states, IDLE and ACTIVE.
REQ-018 In IDLE with en=1 and count>0, the FSM SHALL pop the head code c and register y=8'b1<<c and y_valid=1.
REQ-019 At that pop the FSM SHALL load hcnt=max(hold,1)-1 and move to ACTIVE; otherwise it SHALL stay in IDLE with y=0 and y_valid=0.
REQ-020 In ACTIVE with hcnt>0, the FSM SHALL decrement hcnt and hold y unchanged.
REQ-021 In ACTIVE with hcnt=0, en=1 and count>0, the FSM SHALL pop the next code back-to-back, with no idle cycle, and reload hcnt from the current hold.
REQ-022 In ACTIVE with hcnt=0 otherwise, the FSM SHALL clear y and y_valid and return to IDLE.
REQ-023 hold SHALL be sampled only at pop; hold=0 SHALL behave as hold=1.
REQ-024 A code presented HOLD cycles SHALL give y_valid=1 for exactly max(hold,1) consecutive cycles.
REQ-025 Latency: a code accepted at edge N into an empty queue in IDLE with en=1 SHALL appear on y after edge N+1; there is no same-cycle bypass.
REQ-026 When en goes to 0, no new pop SHALL occur, but the code currently presented SHALL complete its hold; pushes SHALL continue while in_ready=1.
REQ-027 y SHALL always be one-hot while y_valid=1 and all-zero while y_valid=0.
REQ-028 Codes SHALL be presented in strict arrival (FIFO) order.
REQ-029 busy SHALL be combinational: (count!=0) OR y_valid.

Reset
REQ-030 While rst_n=0, y=0, y_valid=0 and busy=0 immediately, independent of clk.
REQ-031 While rst_n=0, count=0, pointers=0, hcnt=0, FSM=IDLE and in_ready=1; queued codes SHALL be discarded.
REQ-032 A reset asserted mid-hold SHALL abort the presented code; after rst_n rises, the first code SHALL be accepted on the next qualifying edge.

Verification
REQ-033 Scenario: reset, en=1, hold=1, push in=3 once -> y=8'b0000_1000 with y_valid=1 for 1 cycle, starting one cycle after acceptance; busy then 0.
REQ-034 Scenario: hold=3, push 0,7 back-to-back -> y=8'h01 for 3 cycles, then 8'h80 for 3 cycles, no gap, then y=0.
REQ-035 Scenario: en=0, push 1,2,4,5 -> in_ready=0 after the 4th push; a 5th code (6) is ignored; en=1 -> y shows 8'h02, 8'h04, 8'h10, 8'h20 in order, and 6 never appears.
REQ-036 Scenario: hold=0 -> each code is held exactly 1 cycle; change hold from 2 to 5 mid-presentation -> current code keeps 2, next code gets 5.
REQ-037 Scenario: queue full while a pop occurs with in_valid=1 -> push rejected; count drops by 1; in_ready=1 the next cycle.
REQ-038 Scenario: rst_n pulled low mid-hold with 2 codes queued -> y=0 and busy=0 asynchronously; after release, no stale code appears.
